// File: rtl/mmio_test_responder.sv
// mmio_test_responder: small MMIO window beside data memory that lets test
// programs report pass/fail, print console bytes and read a cycle counter.
// A watchdog ends the run as TIMEOUT if the program never reports.
module mmio_test_responder #(
  parameter int               XLEN           = 64,
  parameter logic [XLEN-1:0]  BASE_ADDR      = 64'hFFFF_0000,
  parameter int               FIFO_DEPTH     = 8,
  parameter int               TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic            mem_write,
  input  logic            mem_read,
  output logic            hit,
  output logic [XLEN-1:0] rdata,
  output logic            con_valid,
  output logic [7:0]      con_data,
  input  logic            con_ready,
  output logic            done,
  output logic            pass,
  output logic [XLEN-1:0] fail_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;
  localparam logic [1:0] ST_TMO  = 2'd3;

  localparam logic [4:0] OFF_TOHOST  = 5'h00;
  localparam logic [4:0] OFF_CONSOLE = 5'h08;
  localparam logic [4:0] OFF_CYCLE   = 5'h10;
  localparam logic [4:0] OFF_STATUS  = 5'h18;

  logic [1:0]      state;
  logic [XLEN-1:0] code;
  logic [XLEN-1:0] cycle;
  logic            ovf;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   rptr, wptr;
  logic [CW-1:0]   cnt;

  logic [4:0]      off;
  logic            wr, tohost_wr, con_wr;
  logic            to_pass, to_fail, to_tmo;
  logic            full, push, pop;
  logic [XLEN-1:0] status;

  // Address decode: the whole 32-byte window is claimed, even unmapped offsets.
  assign off       = mem_addr[4:0];
  assign hit       = (mem_addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
  assign wr        = hit && mem_write;
  assign tohost_wr = wr && (off == OFF_TOHOST);
  assign con_wr    = wr && (off == OFF_CONSOLE);

  // A TOHOST write of 0 is a no-op, so it does not pre-empt the watchdog.
  assign to_pass = (state == ST_RUN) && tohost_wr && (mem_wdata == XLEN'(1));
  assign to_fail = (state == ST_RUN) && tohost_wr && (mem_wdata != '0) &&
                   (mem_wdata != XLEN'(1));
  assign to_tmo  = (state == ST_RUN) && !to_pass && !to_fail &&
                   (cycle == XLEN'(TIMEOUT_CYCLES - 1));

  // Run-state FSM; terminal states hold until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      code  <= '0;
    end else if (to_pass) begin
      state <= ST_PASS;
    end else if (to_fail) begin
      state <= ST_FAIL;
      code  <= {1'b0, mem_wdata[XLEN-1:1]};
    end else if (to_tmo) begin
      state <= ST_TMO;
    end
  end

  // Cycle counter: counts only on edges that stay in RUN, so it freezes at
  // the value seen in the cycle that ended the run. Saturates.
  always_ff @(posedge clk) begin
    if (reset)
      cycle <= '0;
    else if ((state == ST_RUN) && !(to_pass || to_fail || to_tmo) && (cycle != '1))
      cycle <= cycle + XLEN'(1);
  end

  // Console FIFO control: a push into a full FIFO is allowed when a pop
  // frees the slot on the same edge.
  assign full      = (cnt == CW'(FIFO_DEPTH));
  assign con_valid = (cnt != '0);
  assign pop       = con_valid && con_ready;
  assign push      = con_wr && (!full || pop);

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (con_wr && full && !pop) ovf <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_mem[wptr] <= mem_wdata[7:0];
  end

  assign con_data = con_valid ? fifo_mem[rptr] : 8'h00;

  // STATUS register image.
  always_comb begin
    status        = '0;
    status[1:0]   = state;
    status[2]     = ovf;
    status[15:8]  = 8'(cnt);
  end

  // Zero-latency load mux; write-only and unmapped offsets read 0.
  always_comb begin
    rdata = '0;
    if (hit && mem_read) begin
      case (off)
        OFF_CYCLE:  rdata = cycle;
        OFF_STATUS: rdata = status;
        default:    rdata = '0;
      endcase
    end
  end

  // Result outputs decoded from the run state.
  always_comb begin
    done = (state != ST_RUN);
    pass = (state == ST_PASS);
    case (state)
      ST_FAIL: fail_code = code;
      ST_TMO:  fail_code = '1;
      default: fail_code = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_test_responder.sv
// Directed bench for mmio_test_responder with a console-byte scoreboard.
module tb_mmio_test_responder;

  localparam logic [63:0] BASE = 64'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        con_ready = 1'b0;
  logic        hit, con_valid, done, pass;
  logic [63:0] rdata, fail_code;
  logic [7:0]  con_data;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic        ovf_exp = 1'b0;
  logic [63:0] v;
  int          got;

  mmio_test_responder #(
    .XLEN(64), .BASE_ADDR(BASE), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .hit(hit), .rdata(rdata),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .done(done), .pass(pass), .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; con_ready = 1'b0;
    tick();
    reset = 1'b0;
    sb.delete();
    ovf_exp = 1'b0;
  endtask

  task automatic store(input logic [4:0] off, input logic [63:0] d);
    mem_addr = BASE + 64'(off); mem_wdata = d; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; mem_addr = '0;
  endtask

  task automatic load(input logic [4:0] off, output logic [63:0] val);
    mem_addr = BASE + 64'(off); mem_read = 1'b1;
    #1;
    val = rdata;
    mem_read = 1'b0; mem_addr = '0;
  endtask

  // Model the FIFO: accept while below depth, otherwise expect overflow.
  task automatic con_push(input logic [7:0] b);
    if (sb.size() < 8) sb.push_back(b); else ovf_exp = 1'b1;
    store(5'h08, {56'h0, b});
  endtask

  task automatic drain(input int max, output int n);
    n = 0;
    con_ready = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (!con_valid) break;
      if (sb.size() == 0) check("drain_extra", {63'h0, con_valid}, 64'h0);
      else check("drain_byte", {56'h0, con_data}, {56'h0, sb.pop_front()});
      n++;
      tick();
    end
    con_ready = 1'b0;
    check("drain_valid_low", {63'h0, con_valid}, 64'h0);
    check("drain_sb_left", 64'(sb.size()), 64'h0);
  endtask

  task automatic check_status(input string tag, input logic [1:0] st);
    load(5'h18, v);
    check({tag, "_state"}, {62'h0, v[1:0]}, {62'h0, st});
    check({tag, "_ovf"}, {63'h0, v[2]}, {63'h0, ovf_exp});
    check({tag, "_count"}, {56'h0, v[15:8]}, 64'(sb.size()));
    check({tag, "_zero_bits"}, v & ~64'hFF07, 64'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, {63'h0, done}, 64'h0);
    check({tag, "_pass"}, {63'h0, pass}, 64'h0);
    check({tag, "_fail_code"}, fail_code, 64'h0);
    check({tag, "_con_valid"}, {63'h0, con_valid}, 64'h0);
    check({tag, "_con_data"}, {56'h0, con_data}, 64'h0);
    check({tag, "_rdata_idle"}, rdata, 64'h0);
    load(5'h10, v);
    check({tag, "_cycle"}, v, 64'h0);
    load(5'h18, v);
    check({tag, "_status"}, v, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Test 1: reset values, decode boundaries, PASS and terminal hold.
    do_reset();
    check_reset_vals("rst1");
    mem_addr = BASE + 64'h1F; #1;
    check("hit_top", {63'h0, hit}, 64'h1);
    mem_addr = BASE + 64'h20; mem_read = 1'b1; #1;
    check("hit_above", {63'h0, hit}, 64'h0);
    check("rdata_nohit", rdata, 64'h0);
    mem_read = 1'b0; mem_addr = '0;
    store(5'h00, 64'h0);
    check("tohost0_ignored", {63'h0, done}, 64'h0);
    store(5'h04, 64'h1);
    check("unmapped_wr_ignored", {63'h0, done}, 64'h0);
    load(5'h00, v);
    check("tohost_reads0", v, 64'h0);
    store(5'h00, 64'h1);
    check("pass_done", {63'h0, done}, 64'h1);
    check("pass_pass", {63'h0, pass}, 64'h1);
    check("pass_fc", fail_code, 64'h0);
    store(5'h00, 64'h5);
    check("pass_hold_pass", {63'h0, pass}, 64'h1);
    check("pass_hold_fc", fail_code, 64'h0);
    check_status("pass_st", 2'd1);

    // Test 2: FAIL with shifted code; counter frozen at the reporting cycle.
    do_reset();
    store(5'h00, 64'h0B);
    check("fail_done", {63'h0, done}, 64'h1);
    check("fail_pass", {63'h0, pass}, 64'h0);
    check("fail_fc", fail_code, 64'h5);
    check_status("fail_st", 2'd2);
    tick();
    load(5'h10, v);
    check("fail_cycle_frozen", v, 64'h0);

    // Test 3: overflow drops bytes past depth; drain yields first 8 in order.
    do_reset();
    for (int i = 0; i < 10; i++) con_push(8'(8'h41 + i));
    check_status("ovf_st", 2'd0);
    drain(16, got);
    check("ovf_drained", 64'(got), 64'd8);

    // Test 4: push into full FIFO with simultaneous pop; no overflow.
    do_reset();
    for (int i = 0; i < 8; i++) con_push(8'(8'h30 + i));
    check("full_valid", {63'h0, con_valid}, 64'h1);
    con_ready = 1'b1;
    check("full_head", {56'h0, con_data}, {56'h0, sb.pop_front()});
    sb.push_back(8'h5A);
    store(5'h08, 64'h5A);
    con_ready = 1'b0;
    check_status("pushpop_st", 2'd0);
    drain(16, got);
    check("pushpop_drained", 64'(got), 64'd8);

    // Test 5a: watchdog fires after cycle 19; console still works afterwards.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      load(5'h10, v);
      check("tmo_cycle", v, 64'(c));
      check("tmo_not_done", {63'h0, done}, 64'h0);
      tick();
    end
    check("tmo_done", {63'h0, done}, 64'h1);
    check("tmo_pass", {63'h0, pass}, 64'h0);
    check("tmo_fc", fail_code, '1);
    check_status("tmo_st", 2'd3);
    load(5'h10, v);
    check("tmo_cycle_frozen", v, 64'd19);
    tick();
    load(5'h10, v);
    check("tmo_cycle_frozen2", v, 64'd19);
    con_push(8'h55);
    check("tmo_con_valid", {63'h0, con_valid}, 64'h1);
    drain(4, got);

    // Test 5b: TOHOST write in the watchdog cycle wins.
    do_reset();
    repeat (19) tick();
    load(5'h10, v);
    check("race_cycle", v, 64'd19);
    store(5'h00, 64'h1);
    check("race_pass", {63'h0, pass}, 64'h1);
    check("race_fc", fail_code, 64'h0);
    check_status("race_st", 2'd1);

    // Test 6: reset mid-run clears terminal state and FIFO.
    do_reset();
    store(5'h00, 64'h1);
    for (int i = 0; i < 3; i++) con_push(8'(8'h61 + i));
    check("pre_rst_valid", {63'h0, con_valid}, 64'h1);
    check("pre_rst_done", {63'h0, done}, 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    ovf_exp = 1'b0;
    check_reset_vals("rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_test_responder.md
# mmio_test_responder

Memory-mapped test responder on the processor's data-memory port. It gives RISC-V test programs a way to report results and print characters back to the simulation environment, so a bench can end a run on a real pass or fail instead of a fixed delay. It sits beside data memory inside `RISC_V_Processor`, claims a small address window, and exposes a drainable console stream and pass/fail/timeout status to the bench.

## Interface
- `XLEN`, 64, data and address width.
- `BASE_ADDR`, 64'hFFFF_0000, base of the 32-byte register window. Must be 32-byte aligned.
- `FIFO_DEPTH`, 8, console FIFO entries. Must be a power of two, at least 2.
- `TIMEOUT_CYCLES`, 100000, watchdog limit in cycles since reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_addr`  in  XLEN  byte address from the memory stage.
- `mem_wdata`  in  XLEN  store data.
- `mem_write`  in  1  store strobe, sampled each edge.
- `mem_read`  in  1  load strobe.
- `hit`  out  1  combinational; high when `mem_addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]`. Data memory must ignore accesses while `hit` is high.
- `rdata`  out  XLEN  combinational load data; 0 when `!hit` or `!mem_read`.
- `con_valid`  out  1  FIFO non-empty.
- `con_data`  out  8  FIFO head byte.
- `con_ready`  in  1  bench accepts the head byte; a pop occurs when `con_valid && con_ready`.
- `done`  out  1  the run has finished: pass, fail or timeout.
- `pass`  out  1  the test passed.
- `fail_code`  out  XLEN  failure code; all-ones on timeout.

## Operation
Register map, offset = `mem_addr[4:0]`. Only offsets 0x00, 0x08, 0x10 and 0x18 are decoded; other offsets read 0 and ignore writes.
- 0x00 TOHOST (write-only, reads 0).
  - Writing 1 moves the FSM RUN→PASS.
  - Writing any other nonzero value moves RUN→FAIL with `fail_code = {1'b0, wdata[XLEN-1:1]}`.
  - Writing 0 is ignored.
  - Writes outside RUN are ignored.
- 0x08 CONSOLE (write-only, reads 0).
  - Pushes `wdata[7:0]`.
  - If the FIFO is full and no pop occurs this cycle, the byte is dropped and the sticky `ovf` flag is set.
- 0x10 CYCLE (read-only).
  - Cycle counter: 0 after reset, +1 per cycle while in RUN, frozen otherwise.
  - Saturates at all-ones.
- 0x18 STATUS (read-only).
  - Bits [1:0]: state (RUN=0, PASS=1, FAIL=2, TIMEOUT=3).
  - Bit [2]: `ovf`.
  - Bits [15:8]: FIFO count.
  - All other bits 0.

FSM transitions:
- RUN→PASS or RUN→FAIL on a TOHOST write.
- RUN→TIMEOUT when CYCLE reaches `TIMEOUT_CYCLES - 1` with no TOHOST write that cycle. A TOHOST write in that same cycle wins.
- PASS, FAIL and TIMEOUT are terminal until reset.

Outputs by state:
- `done = (state != RUN)`.
- `pass = (state == PASS)`.
- `fail_code` is 0 except in FAIL (latched code) and TIMEOUT (all-ones).

Console FIFO:
- Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`, plus a count.
- Push and pop in the same cycle: both take effect and the count is unchanged. This includes the full case, so no overflow is flagged.
- The console keeps draining after `done`.
- CONSOLE writes are still accepted after `done`.

A simultaneous `mem_read` and `mem_write` is a protocol error; the write takes effect.

## Timing
- Reset values: `rdata` 0, `hit` follows its decode combinationally, `con_valid` 0, `con_data` 0, `done` 0, `pass` 0, `fail_code` 0, CYCLE 0, `ovf` 0, FIFO empty, state RUN.
- Reset asserted mid-run clears everything on that edge, including FIFO contents, `ovf` and a terminal state.
- Loads have zero latency: `rdata` is valid in the same cycle as `mem_read`.
- A store takes effect at the sampling edge.
  - `done`, `pass` and `fail_code` are high/valid in the cycle after a TOHOST store.
  - `con_valid` is high in the cycle after the first push into an empty FIFO.
- Pop: on an edge where `con_valid && con_ready`, the head byte is consumed and `con_data` shows the next entry from the following cycle.
- CYCLE read in cycle N after reset deassertion returns N, counting the first cycle as 0.

## Test plan
1. Reset, then store 1 to `BASE_ADDR + 0x00` → the next cycle shows `done`=1, `pass`=1, `fail_code`=0. A second store of 5 leaves the outputs unchanged.
2. Store 0x0B to TOHOST → `done`=1, `pass`=0, `fail_code`=5. Load from 0x18 → bits [1:0] = 2.
3. Hold `con_ready`=0 and store "A".."J" (10 bytes) to 0x08 with `FIFO_DEPTH`=8 → count 8, `ovf`=1. Then assert `con_ready` → the bench receives exactly "A".."H" in order, after which `con_valid`=0.
4. Fill the FIFO to 8, then hold `con_ready`=1 while storing "Z" in the same cycle → count stays 8, `ovf` stays 0, and "Z" is drained last.
5. `TIMEOUT_CYCLES`=20 with no TOHOST write → `done`=1 and `fail_code`=all-ones in cycle 20, and CYCLE reads 19 thereafter. A TOHOST write of 1 in cycle 19 must instead yield PASS.
6. Reach PASS, push 3 console bytes, assert reset for one cycle → all outputs return to reset values, FIFO empty, CYCLE = 0.
